// File: rtl/empty_ptr_storage.sv
// empty_ptr_storage: free-pointer FIFO that self-fills with every table address after reset
module empty_ptr_storage #(
    parameter int A_WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [A_WIDTH-1:0] add_empty_ptr_i,
    input  logic               add_empty_ptr_en_i,
    output logic [A_WIDTH-1:0] next_empty_ptr_o,
    output logic               next_empty_ptr_val_o,
    input  logic               next_empty_ptr_rd_ack_i,
    output logic               init_done_o,
    output logic [A_WIDTH:0]   count_o,
    output logic               overflow_err_o,
    output logic               underflow_err_o
);
    localparam int DEPTH = 2 ** A_WIDTH;

    typedef enum logic {INIT_S, RUN_S} state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] ram [DEPTH];
    logic [A_WIDTH-1:0] wr_ptr, rd_ptr, out_ptr, wr_data;
    logic [A_WIDTH:0]   count;
    logic               out_val, ovf, udf;
    logic               wr_en, rd_en, take, ovf_set, udf_set, full;

    assign full                 = count == (A_WIDTH + 1)'(DEPTH);
    assign next_empty_ptr_o     = out_ptr;
    assign next_empty_ptr_val_o = out_val;
    assign init_done_o          = state_q == RUN_S;
    assign count_o              = count;
    assign overflow_err_o       = ovf;
    assign underflow_err_o      = udf;

    // Next state and per-cycle RAM/accounting strobes; during INIT the write pointer doubles as the fill counter
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_data = add_empty_ptr_i;
        rd_en   = 1'b0;
        take    = 1'b0;
        ovf_set = 1'b0;
        udf_set = next_empty_ptr_rd_ack_i && !out_val;
        case (state_q)
            INIT_S: begin
                wr_en   = 1'b1;
                wr_data = wr_ptr;
                ovf_set = add_empty_ptr_en_i;
                state_d = (wr_ptr == A_WIDTH'(DEPTH - 1)) ? RUN_S : INIT_S;
            end
            RUN_S: begin
                wr_en   = add_empty_ptr_en_i && !full;
                ovf_set = add_empty_ptr_en_i && full;
                take    = next_empty_ptr_rd_ack_i && out_val;
                rd_en   = !out_val && count != '0;
            end
            default: state_d = INIT_S;
        endcase
    end

    // State, pointers, output register, count and sticky error flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= INIT_S;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            out_ptr <= '0;
            out_val <= 1'b0;
            count   <= '0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) begin
                rd_ptr  <= rd_ptr + 1'b1;
                out_ptr <= ram[rd_ptr];
            end
            out_val <= rd_en || (out_val && !take);
            count   <= count + (A_WIDTH + 1)'(wr_en) - (A_WIDTH + 1)'(take);
            ovf     <= ovf || ovf_set;
            udf     <= udf || udf_set;
        end
    end

    // Pointer storage write port; contents need no reset because INIT rewrites every entry
    always_ff @(posedge clk_i) begin
        if (wr_en) ram[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_empty_ptr_storage.sv
// tb_empty_ptr_storage: randomized and directed checks of the free-pointer list against a queue model
module tb_empty_ptr_storage;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0, rst = 1'b1, en = 1'b0, ack = 1'b0;
    logic [AW-1:0] aptr = '0;
    logic [AW-1:0] next_ptr;
    logic          next_val, init_done, ovf, udf;
    logic [AW:0]   count;

    int checks = 0, errors = 0;

    logic [AW-1:0] q[$];
    bit            m_val, m_init, m_ovf, m_udf;
    int            icnt;

    empty_ptr_storage #(.A_WIDTH(AW)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .add_empty_ptr_i        (aptr),
        .add_empty_ptr_en_i     (en),
        .next_empty_ptr_o       (next_ptr),
        .next_empty_ptr_val_o   (next_val),
        .next_empty_ptr_rd_ack_i(ack),
        .init_done_o            (init_done),
        .count_o                (count),
        .overflow_err_o         (ovf),
        .underflow_err_o        (udf)
    );

    always #5 clk = ~clk;

    task automatic model_reset;
        q.delete();
        m_val  = 0;
        m_init = 1;
        icnt   = 0;
        m_ovf  = 0;
        m_udf  = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, leave time 1 unit after the edge
    task automatic step(input bit e, input logic [AW-1:0] p, input bit a);
        bit take, add;
        int ram_n;
        en = e; aptr = p; ack = a;
        @(posedge clk);
        if (m_init) begin
            m_ovf |= e;
            m_udf |= a;
            q.push_back(AW'(icnt));
            icnt++;
            if (icnt == DEPTH) m_init = 0;
        end else begin
            take  = a && m_val;
            add   = e && q.size() < DEPTH;
            ram_n = q.size();
            m_udf |= a && !m_val;
            m_ovf |= e && q.size() == DEPTH;
            if (take) void'(q.pop_front());
            if (add) q.push_back(p);
            m_val = m_val ? !take : (ram_n > 0);
        end
        #1;
        en = 0; ack = 0;
    endtask

    task automatic wait_init;
        for (int i = 0; i < DEPTH; i++) step(0, '0, 0);
    endtask

    task automatic take_one(output logic [AW-1:0] got, output bit ok);
        int n = 0;
        while (next_val !== 1'b1 && n < 8) begin
            step(0, '0, 0);
            n++;
        end
        ok  = next_val === 1'b1;
        got = next_ptr;
        if (ok) step(0, '0, 1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if ({next_ptr, next_val, init_done, count, ovf, udf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ptr=%0h val=%0b done=%0b cnt=%0d ovf=%0b udf=%0b exp all 0",
                     next_ptr, next_val, init_done, count, ovf, udf);
        end
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_init;
        for (int i = 0; i < DEPTH; i++) begin
            step(0, '0, 0);
            if (i == DEPTH - 2) begin
                checks++;
                if (init_done !== 1'b0) begin
                    errors++;
                    $display("FAIL init_early got=%0b exp=0", init_done);
                end
            end
        end
        checks++;
        if (init_done !== 1'b1 || count !== 5'd16 || next_val !== 1'b0) begin
            errors++;
            $display("FAIL init_done got done=%0b cnt=%0d val=%0b exp 1 16 0", init_done, count, next_val);
        end
        step(0, '0, 0);
        checks++;
        if (next_val !== 1'b1 || next_ptr !== 4'h0) begin
            errors++;
            $display("FAIL first_ptr got val=%0b ptr=%0h exp 1 0", next_val, next_ptr);
        end
    endtask

    task automatic test_drain;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (next_val !== 1'b1 || next_ptr !== AW'(i)) begin
                errors++;
                $display("FAIL drain_ptr[%0d] got val=%0b ptr=%0h exp 1 %0h", i, next_val, next_ptr, i);
            end
            step(0, '0, 1);
            checks++;
            if (next_val !== 1'b0 || count !== 5'(q.size())) begin
                errors++;
                $display("FAIL drain_gap[%0d] got val=%0b cnt=%0d exp 0 %0d", i, next_val, count, q.size());
            end
            step(0, '0, 0);
        end
        checks++;
        if (count !== 5'd0 || next_val !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got cnt=%0d val=%0b exp 0 0", count, next_val);
        end
    endtask

    task automatic test_fifo_order;
        logic [AW-1:0] exp_ptr [3];
        logic [AW-1:0] got;
        bit ok;
        exp_ptr = '{4'h5, 4'h9, 4'h3};
        step(1, 4'h5, 0);
        checks++;
        if (next_val !== 1'b0 || count !== 5'd1) begin
            errors++;
            $display("FAIL add_first got val=%0b cnt=%0d exp 0 1", next_val, count);
        end
        step(1, 4'h9, 0);
        checks++;
        if (next_val !== 1'b1 || next_ptr !== 4'h5) begin
            errors++;
            $display("FAIL add_to_valid got val=%0b ptr=%0h exp 1 5", next_val, next_ptr);
        end
        step(1, 4'h3, 0);
        checks++;
        if (count !== 5'd3) begin
            errors++;
            $display("FAIL add_peak got cnt=%0d exp 3", count);
        end
        for (int k = 0; k < 3; k++) begin
            take_one(got, ok);
            checks++;
            if (!ok || got !== exp_ptr[k]) begin
                errors++;
                $display("FAIL fifo_order[%0d] got ok=%0b ptr=%0h exp %0h", k, ok, got, exp_ptr[k]);
            end
        end
    endtask

    task automatic test_underflow;
        logic ovf_before;
        ovf_before = ovf;
        step(0, '0, 1);
        checks++;
        if (udf !== 1'b1 || count !== 5'd0 || next_val !== 1'b0 || ovf !== ovf_before) begin
            errors++;
            $display("FAIL underflow got udf=%0b cnt=%0d val=%0b ovf=%0b exp 1 0 0 %0b", udf, count, next_val, ovf, ovf_before);
        end
        step(0, '0, 0);
        checks++;
        if (udf !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky got=%0b exp=1", udf);
        end
    endtask

    task automatic test_full_overflow;
        test_reset();
        wait_init();
        checks++;
        if (count !== 5'd16 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_before got cnt=%0d ovf=%0b exp 16 0", count, ovf);
        end
        step(1, 4'h7, 0);
        checks++;
        if (count !== 5'd16 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL full_add got cnt=%0d ovf=%0b exp 16 1", count, ovf);
        end
        for (int i = 0; i < 3; i++) step(0, '0, 0);
        checks++;
        if (ovf !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL full_sticky got ovf=%0b cnt=%0d exp 1 16", ovf, count);
        end
    endtask

    task automatic test_simultaneous;
        logic [AW-1:0] got;
        bit ok;
        for (int i = 0; i < 12; i++) take_one(got, ok);
        while (next_val !== 1'b1 && !m_val) step(0, '0, 0);
        checks++;
        if (count !== 5'd4 || next_val !== 1'b1) begin
            errors++;
            $display("FAIL simul_setup got cnt=%0d val=%0b exp 4 1", count, next_val);
        end
        step(1, 4'hA, 1);
        checks++;
        if (count !== 5'd4) begin
            errors++;
            $display("FAIL simul_count got=%0d exp=4", count);
        end
        for (int k = 0; k < 4; k++) begin
            logic [AW-1:0] exp_p;
            exp_p = (k == 3) ? 4'hA : AW'(13 + k);
            take_one(got, ok);
            checks++;
            if (!ok || got !== exp_p) begin
                errors++;
                $display("FAIL simul_order[%0d] got ok=%0b ptr=%0h exp %0h", k, ok, got, exp_p);
            end
        end
    endtask

    task automatic test_init_add;
        test_reset();
        step(1, 4'h3, 0);
        checks++;
        if (ovf !== 1'b1 || udf !== 1'b0) begin
            errors++;
            $display("FAIL init_add got ovf=%0b udf=%0b exp 1 0", ovf, udf);
        end
        for (int i = 1; i < DEPTH; i++) step(0, '0, 0);
        checks++;
        if (init_done !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL init_add_done got done=%0b cnt=%0d exp 1 16", init_done, count);
        end
    endtask

    task automatic test_random;
        int bad = 0;
        test_reset();
        wait_init();
        for (int c = 0; c < 500; c++) begin
            step($urandom_range(0, 9) < 4, AW'($urandom), $urandom_range(0, 9) < 5);
            checks++;
            if (count !== 5'(q.size()) || next_val !== m_val || init_done !== !m_init ||
                ovf !== m_ovf || udf !== m_udf || (m_val && next_ptr !== q[0])) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d] got cnt=%0d val=%0b ptr=%0h ovf=%0b udf=%0b exp %0d %0b %0h %0b %0b",
                             c, count, next_val, next_ptr, ovf, udf, q.size(), m_val,
                             (q.size() > 0) ? q[0] : 4'h0, m_ovf, m_udf);
            end
        end
    endtask

    task automatic test_midreset;
        logic [AW-1:0] got;
        bit ok;
        int n = 0;
        test_reset();
        wait_init();
        while (q.size() > 7 && n < 40) begin
            take_one(got, ok);
            n++;
        end
        checks++;
        if (count !== 5'd7) begin
            errors++;
            $display("FAIL midreset_setup got cnt=%0d exp 7", count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({next_ptr, next_val, init_done, count, ovf, udf} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got ptr=%0h val=%0b done=%0b cnt=%0d ovf=%0b udf=%0b exp all 0",
                     next_ptr, next_val, init_done, count, ovf, udf);
        end
        model_reset();
        rst = 1'b0;
        wait_init();
        step(0, '0, 0);
        checks++;
        if (next_val !== 1'b1 || next_ptr !== 4'h0 || count !== 5'd16) begin
            errors++;
            $display("FAIL midreset_restart got val=%0b ptr=%0h cnt=%0d exp 1 0 16", next_val, next_ptr, count);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_drain();
        test_fifo_order();
        test_underflow();
        test_full_overflow();
        test_simultaneous();
        test_init_add();
        test_random();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/empty_ptr_storage.md
# empty_ptr_storage

Free-list manager for the linked-list data table RAM. It holds every data-table address not currently linked into a chain. It hands one free pointer at a time to the enqueue stage and accepts pointers released by the dequeue stage through its add_empty_ptr port. After reset it self-initialises to contain every table address, then runs as a show-ahead FIFO over an internal RAM.

## Interface
- A_WIDTH, default TABLE_ADDR_WIDTH (8 in bench): pointer width; DEPTH = 2**A_WIDTH entries.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- add_empty_ptr_i  in  A_WIDTH  pointer released by the dequeue stage.
- add_empty_ptr_en_i  in  1  single-cycle strobe; add_empty_ptr_i is valid this cycle.
- next_empty_ptr_o  out  A_WIDTH  current free pointer offered to the enqueue stage.
- next_empty_ptr_val_o  out  1  next_empty_ptr_o is valid.
- next_empty_ptr_rd_ack_i  in  1  consumer takes next_empty_ptr_o this cycle.
- init_done_o  out  1  initial fill complete.
- count_o  out  A_WIDTH+1  free pointers held, including the output register.
- overflow_err_o  out  1  sticky; an add arrived when count_o == DEPTH, or during INIT.
- underflow_err_o  out  1  sticky; an ack arrived while next_empty_ptr_val_o == 0.

## Operation
- Storage: DEPTH x A_WIDTH simple dual-port RAM with 1-cycle synchronous read.
- Pointers: wr_ptr and rd_ptr, A_WIDTH bits each, wrap naturally modulo DEPTH.
- Output register out_ptr and out_val drive next_empty_ptr_o and next_empty_ptr_val_o.
- FSM states: INIT_S and RUN_S. There is no other state; illegal encodings go to INIT_S.
- INIT_S (entered on reset):
  - Writes value init_cnt to RAM[init_cnt] for init_cnt = 0..DEPTH-1, one entry per cycle. wr_ptr follows init_cnt.
  - count_o increments with each write.
  - On the write of DEPTH-1: go to RUN_S, set init_done_o, wr_ptr wraps to 0.
- RUN_S:
  - Add: when add_empty_ptr_en_i=1 and count_o < DEPTH, write RAM[wr_ptr], then wr_ptr++ and count_o++.
  - Add when full: when count_o == DEPTH, drop the write and set overflow_err_o.
  - Take: when next_empty_ptr_rd_ack_i=1 and out_val=1, clear out_val and decrement count_o.
  - Take with nothing valid: when out_val=0, ignore the ack and set underflow_err_o.
  - Simultaneous accepted add and take: count_o is unchanged, both pointers advance as usual.
  - Prefetch: when out_val=0, no read is in flight, and the RAM holds at least one entry, issue a read at rd_ptr and increment rd_ptr. On the next cycle load out_ptr and set out_val.
  - Read-after-write to the same address is never issued, because count accounting guarantees the entry was written at least 1 cycle earlier.
- Errors in INIT_S: an add during INIT_S is dropped and sets overflow_err_o, since every pointer is already free. Acks are impossible in INIT_S because val=0; any ack there sets underflow_err_o.
- Sticky error flags clear only on reset.

## Timing
- Reset values:
  - next_empty_ptr_o=0, next_empty_ptr_val_o=0, init_done_o=0, count_o=0.
  - overflow_err_o=0, underflow_err_o=0.
  - wr_ptr=rd_ptr=0, state=INIT_S.
- INIT takes DEPTH cycles after reset deassertion. init_done_o rises on cycle DEPTH. The first read issues in that cycle, and next_empty_ptr_val_o=1 with next_empty_ptr_o=0 on cycle DEPTH+1.
- Take-to-next-valid: ack at cycle t (with RAM non-empty) drops val at t+1, issues the read at t+1, and val=1 at t+2. Sustained rate is 1 pointer per 2 cycles.
- Add-to-valid when fully drained (count_o was 0): add at t, RAM write at t edge, read issued at t+1, val=1 at t+2 with the added pointer.
- Ordering is FIFO: pointers are returned in add order after the initial 0..DEPTH-1 sequence.
- count_o is registered and reflects the events of the previous cycle.
- Reset asserted mid-operation: all state returns to reset values immediately and INIT restarts. Contents of a previous run are discarded.

## Test plan
- Reset with A_WIDTH=4 -> init_done_o rises after 16 cycles, count_o=16, then val=1 with ptr=0. Ack 16 times -> pointers 0..15 in order, each 2 cycles apart. Afterwards count_o=0 and val=0.
- From empty, add 0x5, 0x9, 0x3 on consecutive cycles -> val rises 2 cycles after the first add. Acks return 5, 9, 3. count_o peaks at 3.
- Full table (count_o=16), add 0x7 -> write dropped, count_o stays 16, overflow_err_o=1 and remains set.
- count_o=4 with val=1, add and ack in the same cycle -> count_o stays 4, and the added pointer is returned last.
- Ack while val=0 -> nothing changes except underflow_err_o=1. Add during INIT -> overflow_err_o=1 and init still completes with count_o=16.
- Assert rst_i mid-stream at count_o=7 -> outputs return to reset values at once. After release, INIT repeats and the first pointer is 0.
